usb_stream_ep: RTL and testbench

Bulk endpoint pair that plugs into one OUT and one IN endpoint slot of `usb_fs_pe` and turns them into a plain byte stream for user logic. OUT-packet payload bytes are buffered into an RX FIFO and presented on a valid/ready stream. Bytes pushed on a TX valid/ready stream are buffered and packetised into IN packets of up to `MAX_PKT` bytes. Partial packets are flushed after an idle timeout, and a ZLP terminates a transfer that ended on a full packet. It is a sibling of `usb_spi_bridge_ep` in the endpoint array, for designs that need a raw data pipe instead of the SPI command protocol.

---
 rtl/usb_stream_ep.sv | 193 +++++++++++++++++++
 tb/tb_usb_stream_ep.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_stream_ep.sv
// usb_stream_ep: bulk OUT/IN endpoint pair that turns usb_fs_pe endpoint buffers
// into a plain byte stream (RX FIFO toward user logic, TX FIFO packetised into IN packets).
module usb_stream_ep #(
    parameter int unsigned RX_DEPTH     = 128,
    parameter int unsigned TX_DEPTH     = 128,
    parameter int unsigned MAX_PKT      = 64,
    parameter int unsigned FLUSH_CYCLES = 48000
) (
    input  logic       clk,
    input  logic       reset,
    output logic       out_ep_req,
    input  logic       out_ep_grant,
    input  logic       out_ep_data_avail,
    input  logic       out_ep_setup,
    output logic       out_ep_data_get,
    input  logic [7:0] out_ep_data,
    output logic       out_ep_stall,
    input  logic       out_ep_acked,
    output logic       in_ep_req,
    input  logic       in_ep_grant,
    input  logic       in_ep_data_free,
    output logic       in_ep_data_put,
    output logic [7:0] in_ep_data,
    output logic       in_ep_data_done,
    output logic       in_ep_stall,
    input  logic       in_ep_acked,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready
);
    localparam int unsigned RAW = $clog2(RX_DEPTH);
    localparam int unsigned TAW = $clog2(TX_DEPTH);
    localparam int unsigned NW  = $clog2(MAX_PKT + 1);
    localparam int unsigned FW  = $clog2(FLUSH_CYCLES + 1);

    typedef enum logic [1:0] {O_IDLE, O_REQ, O_READ, O_DRAIN} o_state_t;
    typedef enum logic [2:0] {I_IDLE, I_REQ, I_FILL, I_DONE, I_WAIT} i_state_t;

    o_state_t o_state, o_next;
    i_state_t i_state, i_next;

    logic         unused_inputs;
    assign unused_inputs = out_ep_acked;
    assign out_ep_stall  = 1'b0;
    assign in_ep_stall   = 1'b0;

    // RX FIFO: filled one cycle after each get, drained by the user stream
    logic [7:0]   rx_mem [RX_DEPTH];
    logic [RAW:0] rx_wr, rx_rd, rx_count;
    logic         get_q, keep_q, rx_push, rx_pop;

    assign rx_count = rx_wr - rx_rd;
    assign rx_valid = (rx_count != '0);
    assign rx_pop   = rx_valid && rx_ready;
    assign rx_push  = get_q && keep_q;
    assign rx_data  = rx_valid ? rx_mem[rx_rd[RAW-1:0]] : 8'h00;

    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wr[RAW-1:0]] <= out_ep_data;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_wr  <= '0;
            rx_rd  <= '0;
            get_q  <= 1'b0;
            keep_q <= 1'b0;
        end else begin
            if (rx_push) rx_wr <= rx_wr + (RAW+1)'(1);
            if (rx_pop)  rx_rd <= rx_rd + (RAW+1)'(1);
            get_q  <= out_ep_data_get;
            keep_q <= (o_state == O_READ);
        end
    end

    // OUT FSM: only claims a packet when the whole of it is guaranteed to fit
    always_ff @(posedge clk) begin
        if (!reset) o_state <= O_IDLE;
        else        o_state <= o_next;
    end

    always_comb begin
        o_next          = o_state;
        out_ep_req      = 1'b0;
        out_ep_data_get = 1'b0;
        case (o_state)
            O_IDLE: begin
                if (out_ep_data_avail && (rx_count <= (RAW+1)'(RX_DEPTH - MAX_PKT)))
                    o_next = O_REQ;
            end
            O_REQ: begin
                out_ep_req = 1'b1;
                if (out_ep_grant) o_next = out_ep_setup ? O_DRAIN : O_READ;
            end
            O_READ, O_DRAIN: begin
                out_ep_req      = 1'b1;
                out_ep_data_get = out_ep_data_avail;
                if (!out_ep_data_avail && !get_q) o_next = O_IDLE;
            end
            default: o_next = O_IDLE;
        endcase
    end

    // TX FIFO: pushed by the user stream, popped by IN packet fills
    logic [7:0]   tx_mem [TX_DEPTH];
    logic [TAW:0] tx_wr, tx_rd, tx_count;
    logic         tx_full, tx_push;

    assign tx_count = tx_wr - tx_rd;
    assign tx_full  = (tx_count == (TAW+1)'(TX_DEPTH));
    assign tx_ready = reset && !tx_full;
    assign tx_push  = tx_valid && tx_ready;
    assign in_ep_data = in_ep_data_put ? tx_mem[tx_rd[TAW-1:0]] : 8'h00;

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wr[TAW-1:0]] <= tx_data;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            tx_wr <= '0;
            tx_rd <= '0;
        end else begin
            if (tx_push)        tx_wr <= tx_wr + (TAW+1)'(1);
            if (in_ep_data_put) tx_rd <= tx_rd + (TAW+1)'(1);
        end
    end

    // IN FSM: full packets go at once, partial packets and ZLPs wait for the flush timer
    logic [NW-1:0] n_q, put_cnt, n_take;
    logic [FW-1:0] flush_cnt;
    logic          zlp_pending, expired, pkt_full;

    assign expired  = (flush_cnt == FW'(FLUSH_CYCLES));
    assign pkt_full = (tx_count >= (TAW+1)'(MAX_PKT));
    assign n_take   = pkt_full ? NW'(MAX_PKT) : NW'(tx_count);

    always_ff @(posedge clk) begin
        if (!reset) begin
            i_state     <= I_IDLE;
            n_q         <= '0;
            put_cnt     <= '0;
            zlp_pending <= 1'b0;
            flush_cnt   <= '0;
        end else begin
            i_state <= i_next;
            if (i_state == I_REQ && in_ep_grant) begin
                n_q     <= n_take;
                put_cnt <= '0;
            end else if (in_ep_data_put) begin
                put_cnt <= put_cnt + NW'(1);
            end
            if (i_state == I_WAIT && in_ep_acked) zlp_pending <= (n_q == NW'(MAX_PKT));
            if (tx_push || i_state != I_IDLE) flush_cnt <= '0;
            else if (!expired)                flush_cnt <= flush_cnt + FW'(1);
        end
    end

    always_comb begin
        i_next          = i_state;
        in_ep_req       = 1'b0;
        in_ep_data_put  = 1'b0;
        in_ep_data_done = 1'b0;
        case (i_state)
            I_IDLE: begin
                if (pkt_full || (tx_count != '0 && expired) || (zlp_pending && expired))
                    i_next = I_REQ;
            end
            I_REQ: begin
                in_ep_req = 1'b1;
                if (in_ep_grant) i_next = I_FILL;
            end
            I_FILL: begin
                in_ep_req = 1'b1;
                if (put_cnt == n_q)      i_next = I_DONE;
                else if (in_ep_data_free) in_ep_data_put = 1'b1;
            end
            I_DONE: begin
                in_ep_req       = 1'b1;
                in_ep_data_done = 1'b1;
                i_next          = I_WAIT;
            end
            I_WAIT: begin
                in_ep_req = 1'b1;
                if (in_ep_acked) i_next = I_IDLE;
            end
            default: i_next = I_IDLE;
        endcase
    end
endmodule

// File: tb/tb_usb_stream_ep.sv
// tb_usb_stream_ep: directed bench with a small usb_fs_pe endpoint model on both sides.
module tb_usb_stream_ep;
    localparam int unsigned FLUSH = 2000;

    logic       clk = 1'b0;
    logic       reset;
    logic       out_ep_req, out_ep_grant, out_ep_data_avail, out_ep_setup;
    logic       out_ep_data_get, out_ep_stall;
    logic [7:0] out_ep_data;
    logic       out_ep_acked;
    logic       in_ep_req, in_ep_grant, in_ep_data_free, in_ep_data_put;
    logic [7:0] in_ep_data;
    logic       in_ep_data_done, in_ep_stall;
    logic       in_ep_acked = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid, tx_ready;
    logic       grant_en;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int ord     = 0;
    int lim     = 0;
    logic [7:0] obuf [0:1023];
    logic [7:0] cap [$];
    int         done_cum [$];
    logic [7:0] rxq [$];

    usb_stream_ep #(.RX_DEPTH(128), .TX_DEPTH(128), .MAX_PKT(64), .FLUSH_CYCLES(FLUSH)) dut (
        .clk(clk), .reset(reset),
        .out_ep_req(out_ep_req), .out_ep_grant(out_ep_grant),
        .out_ep_data_avail(out_ep_data_avail), .out_ep_setup(out_ep_setup),
        .out_ep_data_get(out_ep_data_get), .out_ep_data(out_ep_data),
        .out_ep_stall(out_ep_stall), .out_ep_acked(out_ep_acked),
        .in_ep_req(in_ep_req), .in_ep_grant(in_ep_grant),
        .in_ep_data_free(in_ep_data_free), .in_ep_data_put(in_ep_data_put),
        .in_ep_data(in_ep_data), .in_ep_data_done(in_ep_data_done),
        .in_ep_stall(in_ep_stall), .in_ep_acked(in_ep_acked),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // endpoint-side model: OUT bytes come from obuf[ord..lim-1], IN packets are logged
    assign out_ep_data_avail = (ord < lim);
    assign out_ep_grant      = out_ep_req;
    assign in_ep_grant       = in_ep_req && grant_en;
    assign out_ep_acked      = 1'b0;

    always @(posedge clk) begin
        if (out_ep_data_get) begin
            out_ep_data <= obuf[ord];
            ord <= ord + 1;
        end
    end

    always @(posedge clk) begin
        if (in_ep_data_put) cap.push_back(in_ep_data);
        if (in_ep_data_done) done_cum.push_back(cap.size());
        in_ep_acked <= in_ep_data_done;
        if (rx_valid && rx_ready) rxq.push_back(rx_data);
    end

    task automatic push_tx(input logic [7:0] v);
        int g;
        g = 0;
        tx_data  = v;
        tx_valid = 1'b1;
        while (tx_ready !== 1'b1 && g < 5000) begin
            @(negedge clk);
            g++;
        end
        if (g >= 5000) begin
            n_tests++; n_fail++;
            $display("FAIL push_timeout: tx_ready=%b, required 1", tx_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_tests++;
        if ({out_ep_req, out_ep_data_get, out_ep_stall, in_ep_req, in_ep_data_put,
             in_ep_data_done, in_ep_stall, rx_valid, tx_ready} !== 9'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b required 000000000", {out_ep_req, out_ep_data_get,
                     out_ep_stall, in_ep_req, in_ep_data_put, in_ep_data_done, in_ep_stall, rx_valid, tx_ready});
        end
        n_tests++;
        if (in_ep_data !== 8'h00 || rx_data !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_data: in_ep_data=%h rx_data=%h required 00/00", in_ep_data, rx_data);
        end
        reset = 1'b1;
        @(negedge clk);
        n_tests++;
        if (tx_ready !== 1'b1 || in_ep_req !== 1'b0 || out_ep_req !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: tx_ready=%b in_req=%b out_req=%b required 1/0/0",
                     tx_ready, in_ep_req, out_ep_req);
        end
    endtask

    task automatic test_out_packet();
        int base, qb, t0, t1, bad;
        base = lim; qb = rxq.size(); t0 = -1; t1 = -1; bad = 0;
        rx_ready = 1'b1;
        for (int i = 0; i < 10; i++) obuf[base+i] = 8'(i);
        lim = base + 10;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (out_ep_data_get && t0 < 0) t0 = cyc;
            if (rx_valid && t1 < 0) t1 = cyc;
            if (ord == lim && !out_ep_req && t1 >= 0) break;
        end
        n_tests++;
        if (t0 < 0 || t1 - t0 != 2) begin
            n_fail++;
            $display("FAIL out_latency: got %0d cycles required 2", t1 - t0);
        end
        n_tests++;
        if (out_ep_req !== 1'b0 || ord != lim) begin
            n_fail++;
            $display("FAIL out_release: req=%b gets=%0d required 0/%0d", out_ep_req, ord - base, 10);
        end
        repeat (4) @(negedge clk);
        for (int i = 0; i < 10 && qb + i < rxq.size(); i++) if (rxq[qb+i] !== 8'(i)) bad++;
        n_tests++;
        if (rxq.size() - qb != 10 || bad != 0) begin
            n_fail++;
            $display("FAIL out_data: got %0d bytes (%0d wrong) required 10 bytes 00..09", rxq.size() - qb, bad);
        end
    endtask

    task automatic test_setup_drain();
        int base, qb;
        base = lim; qb = rxq.size();
        out_ep_setup = 1'b1;
        for (int i = 0; i < 6; i++) obuf[base+i] = 8'(8'h80 + i);
        lim = base + 6;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (ord == lim && !out_ep_req) break;
        end
        out_ep_setup = 1'b0;
        repeat (4) @(negedge clk);
        n_tests++;
        if (ord != lim || rxq.size() != qb || rx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL setup_drain: got gets=%0d rx_bytes=%0d rx_valid=%b required 6/0/0",
                     ord - base, rxq.size() - qb, rx_valid);
        end
    endtask

    task automatic test_out_backpressure();
        int base, qb, bad;
        base = lim; qb = rxq.size(); bad = 0;
        rx_ready = 1'b0;
        for (int i = 0; i < 192; i++) obuf[base+i] = 8'(i + 1);
        for (int p = 1; p <= 2; p++) begin
            lim = base + 64 * p;
            for (int k = 0; k < 500; k++) begin
                @(negedge clk);
                if (ord == lim && !out_ep_req) break;
            end
        end
        lim = base + 192;
        repeat (300) @(negedge clk);
        n_tests++;
        if (out_ep_req !== 1'b0 || ord != base + 128) begin
            n_fail++;
            $display("FAIL bp_third_held: req=%b gets=%0d required 0/128", out_ep_req, ord - base);
        end
        n_tests++;
        if (rx_valid !== 1'b1 || rx_data !== 8'h01) begin
            n_fail++;
            $display("FAIL bp_head: valid=%b data=%h required 1/01", rx_valid, rx_data);
        end
        rx_ready = 1'b1;
        repeat (63) @(negedge clk);
        rx_ready = 1'b0;
        repeat (20) @(negedge clk);
        n_tests++;
        if (out_ep_req !== 1'b0 || ord != base + 128) begin
            n_fail++;
            $display("FAIL bp_63_free: req=%b gets=%0d required 0/128", out_ep_req, ord - base);
        end
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (out_ep_req === 1'b1) break;
            @(negedge clk);
        end
        n_tests++;
        if (out_ep_req !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_64_free: req=%b required 1", out_ep_req);
        end
        rx_ready = 1'b1;
        for (int k = 0; k < 2000; k++) begin
            if (rxq.size() - qb >= 192 && ord == lim && !out_ep_req) break;
            @(negedge clk);
        end
        for (int i = 0; i < 192 && qb + i < rxq.size(); i++) if (rxq[qb+i] !== 8'(i + 1)) bad++;
        n_tests++;
        if (rxq.size() - qb != 192 || bad != 0) begin
            n_fail++;
            $display("FAIL bp_data: got %0d bytes (%0d wrong) required 192 in order", rxq.size() - qb, bad);
        end
    endtask

    task automatic test_full_in();
        int cb, db, ta, td, len, bad;
        cb = cap.size(); db = done_cum.size(); bad = 0; td = -1;
        grant_en = 1'b1;
        for (int i = 0; i < 64; i++) push_tx(8'(8'hA0 + i));
        tx_valid = 1'b0;
        n_tests++;
        if (in_ep_req !== 1'b0) begin
            n_fail++;
            $display("FAIL in_req_early: req=%b required 0", in_ep_req);
        end
        @(negedge clk);
        n_tests++;
        if (in_ep_req !== 1'b1) begin
            n_fail++;
            $display("FAIL in_req_latency: req=%b required 1", in_ep_req);
        end
        for (int k = 0; k < 500; k++) begin
            if (done_cum.size() > db && !in_ep_req) break;
            @(negedge clk);
        end
        ta = cyc;
        len = (done_cum.size() > db) ? done_cum[db] - cb : -1;
        for (int i = 0; i < 64 && cb + i < cap.size(); i++) if (cap[cb+i] !== 8'(8'hA0 + i)) bad++;
        n_tests++;
        if (len != 64 || done_cum.size() != db + 1 || bad != 0) begin
            n_fail++;
            $display("FAIL full_pkt: len=%0d dones=%0d wrong=%0d required 64/1/0", len, done_cum.size() - db, bad);
        end
        for (int k = 0; k < FLUSH + 500; k++) begin
            if (done_cum.size() > db + 1) begin td = cyc; break; end
            @(negedge clk);
        end
        len = (done_cum.size() > db + 1) ? done_cum[db+1] - done_cum[db] : -1;
        n_tests++;
        if (len != 0 || td - ta < FLUSH) begin
            n_fail++;
            $display("FAIL zlp: len=%0d after %0d cycles required 0 after >= %0d", len, td - ta, FLUSH);
        end
        for (int k = 0; k < 50 && in_ep_req; k++) @(negedge clk);
    endtask

    task automatic test_partial_flush();
        int cb, db, p, d, len, bad;
        cb = cap.size(); db = done_cum.size(); bad = 0; d = -1;
        for (int i = 0; i < 5; i++) push_tx(8'(8'h11 + i));
        tx_valid = 1'b0;
        p = cyc;
        for (int k = 0; k < FLUSH + 100; k++) begin
            if (in_ep_req === 1'b1) begin d = cyc - p; break; end
            @(negedge clk);
        end
        n_tests++;
        if (d != FLUSH + 1) begin
            n_fail++;
            $display("FAIL flush_latency: got %0d required %0d", d, FLUSH + 1);
        end
        for (int k = 0; k < 100 && done_cum.size() == db; k++) @(negedge clk);
        len = (done_cum.size() > db) ? done_cum[db] - cb : -1;
        for (int i = 0; i < 5 && cb + i < cap.size(); i++) if (cap[cb+i] !== 8'(8'h11 + i)) bad++;
        n_tests++;
        if (len != 5 || bad != 0) begin
            n_fail++;
            $display("FAIL partial_pkt: len=%0d wrong=%0d required 5/0", len, bad);
        end
        repeat (FLUSH + 200) @(negedge clk);
        n_tests++;
        if (done_cum.size() != db + 1) begin
            n_fail++;
            $display("FAIL no_zlp: got %0d packets required 1", done_cum.size() - db);
        end
    endtask

    task automatic test_simultaneous();
        int cb, db, bad, l0, l1, l2;
        cb = cap.size(); db = done_cum.size(); bad = 0;
        grant_en = 1'b0;
        for (int i = 0; i < 128; i++) push_tx(8'(i));
        n_tests++;
        if (tx_ready !== 1'b0 || in_ep_req !== 1'b1) begin
            n_fail++;
            $display("FAIL tx_full: tx_ready=%b in_req=%b required 0/1", tx_ready, in_ep_req);
        end
        grant_en = 1'b1;
        for (int i = 128; i < 160; i++) push_tx(8'(i));
        tx_valid = 1'b0;
        for (int k = 0; k < FLUSH + 3000; k++) begin
            if (done_cum.size() >= db + 3 && !in_ep_req) break;
            @(negedge clk);
        end
        l0 = (done_cum.size() > db)     ? done_cum[db] - cb               : -1;
        l1 = (done_cum.size() > db + 1) ? done_cum[db+1] - done_cum[db]   : -1;
        l2 = (done_cum.size() > db + 2) ? done_cum[db+2] - done_cum[db+1] : -1;
        n_tests++;
        if (l0 != 64 || l1 != 64 || l2 != 32) begin
            n_fail++;
            $display("FAIL simul_lengths: got %0d/%0d/%0d required 64/64/32", l0, l1, l2);
        end
        for (int i = 0; i < 160 && cb + i < cap.size(); i++) if (cap[cb+i] !== 8'(i)) bad++;
        n_tests++;
        if (cap.size() - cb != 160 || bad != 0) begin
            n_fail++;
            $display("FAIL simul_data: got %0d bytes (%0d wrong) required 160 in order", cap.size() - cb, bad);
        end
    endtask

    task automatic test_reset_mid();
        int cb, db, cb2, len, bad;
        bad = 0;
        grant_en = 1'b0;
        for (int i = 0; i < 64; i++) push_tx(8'(8'h40 + i));
        tx_valid = 1'b0;
        cb = cap.size(); db = done_cum.size();
        grant_en = 1'b1;
        for (int k = 0; k < 200 && cap.size() - cb < 20; k++) @(negedge clk);
        n_tests++;
        if (in_ep_data_put !== 1'b1 || cap.size() - cb != 20) begin
            n_fail++;
            $display("FAIL mid_fill: put=%b puts=%0d required 1/20", in_ep_data_put, cap.size() - cb);
        end
        reset = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({out_ep_req, out_ep_data_get, in_ep_req, in_ep_data_put, in_ep_data_done,
             rx_valid, tx_ready, in_ep_data} !== 15'b0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: got %b required all 0", {out_ep_req, out_ep_data_get,
                     in_ep_req, in_ep_data_put, in_ep_data_done, rx_valid, tx_ready, in_ep_data});
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_tests++;
        if (done_cum.size() != db || tx_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_abort: dones=%0d tx_ready=%b required 0/1", done_cum.size() - db, tx_ready);
        end
        cb2 = cap.size();
        for (int i = 0; i < 3; i++) push_tx(8'(8'h31 + i));
        tx_valid = 1'b0;
        for (int k = 0; k < FLUSH + 300; k++) begin
            if (done_cum.size() > db && !in_ep_req) break;
            @(negedge clk);
        end
        len = (done_cum.size() > db) ? done_cum[db] - cb2 : -1;
        for (int i = 0; i < 3 && cb2 + i < cap.size(); i++) if (cap[cb2+i] !== 8'(8'h31 + i)) bad++;
        n_tests++;
        if (len != 3 || bad != 0) begin
            n_fail++;
            $display("FAIL post_reset_pkt: len=%0d wrong=%0d required 3/0", len, bad);
        end
    endtask

    initial begin
        reset = 1'b0; rx_ready = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
        out_ep_setup = 1'b0; in_ep_data_free = 1'b1; grant_en = 1'b0;
        test_reset();
        test_out_packet();
        test_setup_drain();
        test_out_backpressure();
        test_full_in();
        test_partial_flush();
        test_simultaneous();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end
endmodule
